// File: rtl/cache_mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the cache line-fill / writeback
//   memory controller.
//   - mc_state_t   : controller FSM state encoding
//   - DEF_*        : default parameter values of cache_mem_ctrl
//   - LINE_W       : bits per cache line at the default geometry
//   - WORD_BYTES   : bytes per memory word at the default geometry
//   - CNT_W        : width of the beat counter at the default geometry
package mem_ctrl_pkg;

   localparam int DEF_ADDRESS_WIDTH = 32;
   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_BLOCK_SIZE    = 4;

   localparam int LINE_W     = DEF_DATA_WIDTH * DEF_BLOCK_SIZE;
   localparam int WORD_BYTES = DEF_DATA_WIDTH / 8;
   localparam int CNT_W      = $clog2(DEF_BLOCK_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } mc_state_t;

endpackage

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl
//   Sits between the data cache's line-wide miss port and word-wide main
//   memory. One miss is accepted in IDLE, carrying a line fill request and
//   an optional dirty-victim writeback. The writeback goes out first as
//   BLOCK_SIZE single-word writes, then the fill comes in as BLOCK_SIZE
//   single-word reads. The assembled line is presented with a one-cycle
//   fill_valid pulse while busy is still high.
//
//   Memory handshake: a transaction is one cycle or more with exactly one
//   of mem_we/mem_re high. Strobe, mem_addr and mem_wdata stay constant
//   until the cycle in which mem_ready is high; that cycle completes the
//   word (and, for a read, mem_rdata is captured). mem_ready with no
//   strobe active has no effect.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_addr      line fill request (byte address)
//   wb_valid, wb_addr,
//   wb_data                  dirty victim line to write back
//   busy                     controller not idle, cache must stall
//   fill_valid, fill_data    assembled line, one-cycle pulse
//   mem_addr, mem_wdata,
//   mem_we, mem_re           word transaction to memory
//   mem_rdata, mem_ready     memory response
module cache_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_valid,
   input  logic [ADDRESS_WIDTH-1:0]            req_addr,
   input  logic                                wb_valid,
   input  logic [ADDRESS_WIDTH-1:0]            wb_addr,
   input  logic [DATA_WIDTH*BLOCK_SIZE-1:0]    wb_data,
   output logic                                busy,
   output logic                                fill_valid,
   output logic [DATA_WIDTH*BLOCK_SIZE-1:0]    fill_data,
   output logic [ADDRESS_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   output logic                                mem_we,
   output logic                                mem_re,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   input  logic                                mem_ready
);

   localparam int LINE_BITS = DATA_WIDTH * BLOCK_SIZE;
   localparam int WORD_B    = DATA_WIDTH / 8;
   localparam int CW        = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int OFF_W     = $clog2(LINE_BITS / 8);

   // Clears the byte-within-line offset so latched addresses are line bases.
   localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
      {{(ADDRESS_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_SIZE - 1);

   mc_state_t                state, state_nxt;
   logic [CW-1:0]            cnt;
   logic [ADDRESS_WIDTH-1:0] req_base;
   logic [ADDRESS_WIDTH-1:0] wb_base;
   logic [LINE_BITS-1:0]     wb_line;
   logic                     have_req;
   logic [ADDRESS_WIDTH-1:0] beat_off;
   logic                     accept;
   logic                     last_beat;

   assign accept    = (state == IDLE) && (wb_valid || req_valid);
   assign last_beat = (cnt == LAST_BEAT);
   // Offsets never exceed one line, so base + offset cannot leave the line.
   assign beat_off  = ADDRESS_WIDTH'(cnt) * ADDRESS_WIDTH'(WORD_B);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wb_valid)       state_nxt = WB;
            else if (req_valid) state_nxt = FILL;
         end
         WB: begin
            if (mem_ready && last_beat) state_nxt = have_req ? FILL : IDLE;
         end
         FILL: begin
            if (mem_ready && last_beat) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy       = (state != IDLE);
      fill_valid = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         WB: begin
            mem_we    = 1'b1;
            mem_addr  = wb_base + beat_off;
            mem_wdata = wb_line[cnt*DATA_WIDTH +: DATA_WIDTH];
         end
         FILL: begin
            mem_re   = 1'b1;
            mem_addr = req_base + beat_off;
         end
         DONE:    fill_valid = 1'b1;
         default: ;
      endcase
   end

   // Beat counter and line registers. Inputs are captured only on
   // acceptance, so the cache may change them freely while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         req_base  <= '0;
         wb_base   <= '0;
         wb_line   <= '0;
         have_req  <= 1'b0;
         fill_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_base <= req_addr & LINE_MASK;
                  wb_base  <= wb_addr & LINE_MASK;
                  wb_line  <= wb_data;
                  have_req <= req_valid;
                  cnt      <= '0;
               end
            end
            WB: begin
               if (mem_ready) cnt <= last_beat ? '0 : cnt + 1'b1;
            end
            FILL: begin
               if (mem_ready) begin
                  fill_data[cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                  cnt <= last_beat ? '0 : cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl
//   Directed bench for cache_mem_ctrl. The bench plays main memory cycle by
//   cycle: read data for address A is 32'hCAFE_0000 | A[15:0]; during wait
//   cycles the data bus carries 32'hDEAD_BEEF so an early capture shows up.
module tb_cache_mem_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic [31:0]  req_addr;
   logic         wb_valid;
   logic [31:0]  wb_addr;
   logic [127:0] wb_data;
   logic         busy;
   logic         fill_valid;
   logic [127:0] fill_data;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_we;
   logic         mem_re;
   logic [31:0]  mem_rdata;
   logic         mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // clock / reset
   always #5 clk = ~clk;

   cache_mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .busy       (busy),
      .fill_valid (fill_valid),
      .fill_data  (fill_data),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return 32'hCAFE_0000 | {16'h0, a[15:0]};
   endfunction

   // Called in the first cycle after acceptance. Plays n_wb write beats and
   // n_rd read beats with 'stall' wait cycles before each completion, then
   // checks DONE (or the return to IDLE for writeback only) lands on cycle
   // exp_end counted from acceptance, and finishes in the following IDLE cycle.
   task automatic run_txn(input int n_wb, input logic [31:0] wb_b, input logic [127:0] line,
                          input int n_rd, input logic [31:0] rd_b, input logic [127:0] exp_fill,
                          input int stall, input int exp_end, input string name);
      int cyc;
      logic [31:0] ea;
      cyc = 1;
      for (int i = 0; i < n_wb; i++) begin
         ea = wb_b + 32'(4 * i);
         for (int s = 0; s <= stall; s++) begin
            mem_ready = (s == stall);
            mem_rdata = 32'hDEAD_BEEF;
            check($sformatf("%s_wb_we%0d_%0d", name, i, s), mem_we, 1'b1);
            check($sformatf("%s_wb_re%0d_%0d", name, i, s), mem_re, 1'b0);
            check($sformatf("%s_wb_addr%0d_%0d", name, i, s), mem_addr, ea);
            check($sformatf("%s_wb_data%0d_%0d", name, i, s), mem_wdata, line[i*32 +: 32]);
            check($sformatf("%s_wb_fv%0d_%0d", name, i, s), fill_valid, 1'b0);
            step();
            cyc++;
         end
      end
      for (int i = 0; i < n_rd; i++) begin
         ea = rd_b + 32'(4 * i);
         for (int s = 0; s <= stall; s++) begin
            mem_ready = (s == stall);
            mem_rdata = (s == stall) ? rd_word(ea) : 32'hDEAD_BEEF;
            check($sformatf("%s_rd_re%0d_%0d", name, i, s), mem_re, 1'b1);
            check($sformatf("%s_rd_we%0d_%0d", name, i, s), mem_we, 1'b0);
            check($sformatf("%s_rd_addr%0d_%0d", name, i, s), mem_addr, ea);
            check($sformatf("%s_rd_busy%0d_%0d", name, i, s), busy, 1'b1);
            step();
            cyc++;
         end
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      check($sformatf("%s_end_cycle", name), cyc, exp_end);
      if (n_rd > 0) begin
         check($sformatf("%s_done_fv", name), fill_valid, 1'b1);
         check($sformatf("%s_done_busy", name), busy, 1'b1);
         check($sformatf("%s_done_strobes", name), {mem_we, mem_re}, 2'b00);
         check($sformatf("%s_done_data", name), fill_data, exp_fill);
         step();
         check($sformatf("%s_idle_data_stable", name), fill_data, exp_fill);
      end
      check($sformatf("%s_idle_busy", name), busy, 1'b0);
      check($sformatf("%s_idle_fv", name), fill_valid, 1'b0);
      check($sformatf("%s_idle_strobes", name), {mem_we, mem_re}, 2'b00);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      wb_valid  = 1'b0;
      wb_addr   = 32'h0;
      wb_data   = 128'h0;
      mem_rdata = 32'h0;
      mem_ready = 1'b0;

      // 1. reset state
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_fv", fill_valid, 1'b0);
      check("rst_strobes", {mem_we, mem_re}, 2'b00);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_fill", fill_data, 128'h0);
      rst = 1'b0;
      step();
      check("post_rst_busy", busy, 1'b0);

      // mem_ready with no strobe is ignored
      mem_ready = 1'b1;
      step();
      check("idle_ready_busy", busy, 1'b0);
      check("idle_ready_re", mem_re, 1'b0);
      mem_ready = 1'b0;

      // 2. fill only, minimum latency
      req_addr  = 32'h0000_1234;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      run_txn(0, 32'h0, 128'h0, 4, 32'h0000_1230,
              {32'hCAFE_123C, 32'hCAFE_1238, 32'hCAFE_1234, 32'hCAFE_1230}, 0, 5, "fill");

      // 3. writeback then fill
      wb_addr   = 32'h0000_0080;
      wb_data   = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
      wb_valid  = 1'b1;
      req_addr  = 32'h0000_0040;
      req_valid = 1'b1;
      step();
      wb_valid  = 1'b0;
      req_valid = 1'b0;
      wb_data   = 128'h0;
      run_txn(4, 32'h0000_0080, {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111},
              4, 32'h0000_0040,
              {32'hCAFE_004C, 32'hCAFE_0048, 32'hCAFE_0044, 32'hCAFE_0040}, 0, 9, "wbfill");

      // 4. three wait cycles on every beat
      req_addr  = 32'h0000_200F;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      run_txn(0, 32'h0, 128'h0, 4, 32'h0000_2000,
              {32'hCAFE_200C, 32'hCAFE_2008, 32'hCAFE_2004, 32'hCAFE_2000}, 3, 17, "stall");

      // 5. writeback only at the top of the address space
      wb_addr  = 32'hFFFF_FFFC;
      wb_data  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      wb_valid = 1'b1;
      step();
      wb_valid = 1'b0;
      run_txn(4, 32'hFFFF_FFF0, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001},
              0, 32'h0, 128'h0, 0, 5, "wbonly");
      step();
      check("wbonly_still_idle", busy, 1'b0);

      // 6. address changed while busy; the held request is taken right after DONE
      req_addr  = 32'h0000_3008;
      req_valid = 1'b1;
      step();
      req_addr  = 32'h0000_5555;
      run_txn(0, 32'h0, 128'h0, 4, 32'h0000_3000,
              {32'hCAFE_300C, 32'hCAFE_3008, 32'hCAFE_3004, 32'hCAFE_3000}, 0, 5, "hold1");
      step();
      req_valid = 1'b0;
      run_txn(0, 32'h0, 128'h0, 4, 32'h0000_5550,
              {32'hCAFE_555C, 32'hCAFE_5558, 32'hCAFE_5554, 32'hCAFE_5550}, 0, 5, "hold2");

      // 1b. reset during the second fill beat
      req_addr  = 32'h0000_1234;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_2222;
      step();
      mem_ready = 1'b0;
      check("midrst_beat1_re", mem_re, 1'b1);
      check("midrst_beat1_addr", mem_addr, 32'h0000_1234);
      rst = 1'b1;
      step();
      check("midrst_busy", busy, 1'b0);
      check("midrst_strobes", {mem_we, mem_re}, 2'b00);
      check("midrst_addr", mem_addr, 32'h0);
      check("midrst_fill", fill_data, 128'h0);
      rst = 1'b0;
      mem_ready = 1'b1;
      step();
      check("midrst_after_busy", busy, 1'b0);
      check("midrst_after_strobes", {mem_we, mem_re}, 2'b00);
      mem_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
